// File: rtl/ring_counter_mm.sv
// Multi-mode ring / Johnson counter used as a one-hot or thermometer phase generator.
// Steps left or right, supports parallel load, and forces illegal states back to the seed.
module ring_counter_mm #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic         dir,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         wrap,
    output logic         err
);

    localparam logic [N-1:0] Seed = N'(1);

    logic [N-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;

    logic [N-1:0] step_val;
    logic [N-2:0] trans;
    logic         ring_ok, john_ok, legal;

    // A ring state is legal when exactly one bit is set.
    // A Johnson state is legal when it has at most one adjacent-bit transition.
    always_comb begin
        trans   = count_q[N-2:0] ^ count_q[N-1:1];
        ring_ok = (count_q != '0) && ((count_q & (count_q - N'(1))) == '0);
        john_ok = (trans & (trans - (N-1)'(1))) == '0;
        legal   = mode ? john_ok : ring_ok;
    end

    always_comb begin
        step_val = count_q;
        unique case ({mode, dir})
            2'b00: step_val = {count_q[N-2:0], count_q[N-1]};
            2'b01: step_val = {count_q[0], count_q[N-1:1]};
            2'b10: step_val = {count_q[N-2:0], ~count_q[N-1]};
            2'b11: step_val = {~count_q[0], count_q[N-1:1]};
            default: step_val = count_q;
        endcase
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (legal) begin
                count_d = step_val;
                wrap_d  = (step_val == Seed);
            end else begin
                count_d = Seed;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= Seed;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ring_counter_mm.sv
// Directed bench for ring_counter_mm (N=4): the driver queues hand-computed expectations
// and an independent monitor compares them one clock later.
module tb_ring_counter_mm;

    logic       clk = 1'b0;
    logic       rst, en, mode, dir, load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       wrap, err;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned step_id = 0;

    typedef struct packed {
        logic [3:0]  c;
        logic        w;
        logic        e;
        int unsigned id;
    } exp_t;

    exp_t sb[$];

    ring_counter_mm #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Drive one edge's inputs and queue what the DUT must show after that edge.
    task automatic step(input logic r, input logic ld, input logic e, input logic m,
                        input logic d, input logic [3:0] lv,
                        input logic [3:0] xc, input logic xw, input logic xe);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; en = e; mode = m; dir = d; load_val = lv;
        step_id++;
        x.c = xc; x.w = xw; x.e = xe; x.id = step_id;
        sb.push_back(x);
    endtask

    // Monitor: one pop per rising edge when an expectation is pending.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                total++;
                if (count !== x.c || wrap !== x.w || err !== x.e) begin
                    bad++;
                    $display("FAIL step%0d: got count=%b wrap=%b err=%b, want count=%b wrap=%b err=%b",
                             x.id, count, wrap, err, x.c, x.w, x.e);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load_val = 4'b0000;

        // Reset dominates load and en.
        step(0, 1, 1, 0, 0, 4'b1010, 4'b0001, 0, 0);
        step(0, 1, 1, 0, 0, 4'b1010, 4'b0001, 0, 0);

        // Ring left, two full periods.
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 1, 0, 0, 4'b0000, 4'b0010, 0, 0);
            step(1, 0, 1, 0, 0, 4'b0000, 4'b0100, 0, 0);
            step(1, 0, 1, 0, 0, 4'b0000, 4'b1000, 0, 0);
            step(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0);
        end

        // Johnson left from reset, then Johnson right.
        step(0, 0, 0, 1, 0, 4'b0000, 4'b0001, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b0011, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b0111, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b1111, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b1110, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b1100, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b1000, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b0001, 1, 0);
        step(1, 0, 1, 1, 1, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 1, 1, 1, 4'b0000, 4'b1000, 0, 0);
        step(1, 0, 1, 1, 1, 4'b0000, 4'b1100, 0, 0);
        step(1, 0, 1, 1, 1, 4'b0000, 4'b1110, 0, 0);
        step(1, 0, 1, 1, 1, 4'b0000, 4'b1111, 0, 0);
        step(1, 0, 1, 1, 1, 4'b0000, 4'b0111, 0, 0);
        step(1, 0, 1, 1, 1, 4'b0000, 4'b0011, 0, 0);
        step(1, 0, 1, 1, 1, 4'b0000, 4'b0001, 1, 0);

        // Ring right from reset, then hold.
        step(0, 0, 0, 0, 1, 4'b0000, 4'b0001, 0, 0);
        step(1, 0, 1, 0, 1, 4'b0000, 4'b1000, 0, 0);
        step(1, 0, 1, 0, 1, 4'b0000, 4'b0100, 0, 0);
        step(1, 0, 1, 0, 1, 4'b0000, 4'b0010, 0, 0);
        step(1, 0, 1, 0, 1, 4'b0000, 4'b0001, 1, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1, 4'b0000, 4'b0001, 0, 0);

        // Illegal-state handling.
        step(1, 1, 1, 0, 0, 4'b0101, 4'b0101, 0, 0);
        step(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 1);
        step(1, 1, 0, 1, 0, 4'b0110, 4'b0110, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b0001, 0, 1);
        step(1, 1, 0, 1, 0, 4'b1100, 4'b1100, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b1000, 0, 0);
        step(1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 1);
        step(1, 0, 1, 0, 0, 4'b0000, 4'b0010, 0, 0);

        // Mid-run reset in Johnson, then a mode switch onto an illegal ring state.
        step(0, 0, 0, 1, 0, 4'b0000, 4'b0001, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b0011, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b0111, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b1111, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b1110, 0, 0);
        step(0, 0, 1, 1, 0, 4'b0000, 4'b0001, 0, 0);
        step(1, 0, 1, 1, 0, 4'b0000, 4'b0011, 0, 0);
        step(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 1);
        step(1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0);

        // Give the monitor a bounded window to drain the scoreboard.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
